// File: rtl/seq_alu.sv
// seq_alu: sequential RISC-V integer ALU with an optional iterative M-extension unit.
//
// Handshake: a request is accepted on a rising edge with in_valid & in_ready.
// in_ready is high only in IDLE. Single-cycle ops complete one cycle after the
// accept. Multiply/divide ops spend XLEN cycles in BUSY, one bit per cycle.
// The result is held in DONE until out_ready is seen.
//
// Ports:
//   clk, reset                    clock and synchronous active-high reset
//   in_valid / in_ready           request handshake
//   op_code, funct3, funct7       instruction fields, captured on accept
//   input1_value, input2_value    operands (rs1/PC, rs2/immediate)
//   out_valid / out_ready         result handshake
//   alu_output_value, illegal     result, and a flag for unsupported encodings
module seq_alu #(
   parameter int XLEN      = 32,
   parameter int MULDIV_EN = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [6:0]      op_code,
   input  logic [2:0]      funct3,
   input  logic [6:0]      funct7,
   input  logic [XLEN-1:0] input1_value,
   input  logic [XLEN-1:0] input2_value,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] alu_output_value,
   output logic            illegal
);

   localparam int SHW = $clog2(XLEN);
   localparam logic [SHW-1:0] LAST = SHW'(XLEN - 1);

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] F7_BASE  = 7'b0000000;
   localparam logic [6:0] F7_ALT   = 7'b0100000;
   localparam logic [6:0] F7_M     = 7'b0000001;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t          state;
   logic [XLEN-1:0] result;
   logic            illegal_q;
   logic [2:0]      m_f3;
   logic [SHW-1:0]  count;
   logic [XLEN-1:0] opa, hi, lo;
   logic            neg_q, neg_r;

   assign in_ready         = (state == IDLE);
   assign out_valid        = (state == DONE);
   assign alu_output_value = result;
   assign illegal          = illegal_q;

   function automatic logic [XLEN-1:0] base_op(input logic [2:0] f3, input logic alt,
                                               input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      logic [SHW-1:0]  sh;
      logic [XLEN-1:0] sra_v;
      sh    = b[SHW-1:0];
      // Kept as a separate statement so the shift stays signed (arithmetic).
      sra_v = $signed(a) >>> sh;
      case (f3)
         3'b000:  base_op = alt ? a - b : a + b;
         3'b001:  base_op = a << sh;
         3'b010:  base_op = XLEN'($signed(a) < $signed(b));
         3'b011:  base_op = XLEN'(a < b);
         3'b100:  base_op = a ^ b;
         3'b101:  base_op = alt ? sra_v : a >> sh;
         3'b110:  base_op = a | b;
         default: base_op = a & b;
      endcase
   endfunction

   // Single-cycle decode and result.
   logic [XLEN-1:0] sum, sc_res;
   logic            sc_ill, is_m, eq, lt, ltu;

   assign sum = input1_value + input2_value;
   assign eq  = (input1_value == input2_value);
   assign lt  = ($signed(input1_value) < $signed(input2_value));
   assign ltu = (input1_value < input2_value);

   always_comb begin
      sc_res = '0;
      sc_ill = 1'b0;
      is_m   = 1'b0;
      case (op_code)
         OP_R: begin
            if (funct7 == F7_M) begin
               if (MULDIV_EN != 0) is_m = 1'b1;
               else                sc_ill = 1'b1;
            end else if (funct7 == F7_BASE ||
                         (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))) begin
               sc_res = base_op(funct3, funct7[5], input1_value, input2_value);
            end else begin
               sc_ill = 1'b1;
            end
         end
         OP_I: sc_res = base_op(funct3, (funct3 == 3'b101) & input2_value[10],
                                input1_value, input2_value);
         OP_BR: begin
            case (funct3)
               3'b000:  sc_res = XLEN'(eq);
               3'b001:  sc_res = XLEN'(!eq);
               3'b100:  sc_res = XLEN'(lt);
               3'b101:  sc_res = XLEN'(!lt);
               3'b110:  sc_res = XLEN'(ltu);
               3'b111:  sc_res = XLEN'(!ltu);
               default: sc_ill = 1'b1;
            endcase
         end
         OP_LOAD, OP_STORE, OP_JAL, OP_AUIPC: sc_res = sum;
         OP_JALR: sc_res = {sum[XLEN-1:1], 1'b0};
         OP_LUI:  sc_res = input2_value;
         default: sc_ill = 1'b1;
      endcase
   end

   // M-extension setup: both units work on magnitudes, sign is fixed at the end.
   logic            sgn_a, sgn_b, a_neg, b_neg;
   logic [XLEN-1:0] abs_a, abs_b;

   assign sgn_a = funct3 inside {3'b001, 3'b010, 3'b100, 3'b110};
   assign sgn_b = funct3 inside {3'b001, 3'b100, 3'b110};
   assign a_neg = sgn_a & input1_value[XLEN-1];
   assign b_neg = sgn_b & input2_value[XLEN-1];
   assign abs_a = a_neg ? -input1_value : input1_value;
   assign abs_b = b_neg ? -input2_value : input2_value;

   // One iteration. Multiply: shift-add with {hi,lo} as the product register.
   // Divide: restoring division, hi = partial remainder, lo = dividend/quotient.
   logic [XLEN:0]   mul_sum;
   logic [XLEN+1:0] div_diff;
   logic            div_ok;
   logic [XLEN-1:0] step_hi, step_lo, m_res;
   logic [2*XLEN-1:0] prod;

   assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opa} : '0);
   assign div_diff = {1'b0, hi, lo[XLEN-1]} - {2'b00, opa};
   assign div_ok   = ~div_diff[XLEN+1];

   always_comb begin
      if (m_f3[2]) begin
         step_hi = div_ok ? div_diff[XLEN-1:0] : {hi[XLEN-2:0], lo[XLEN-1]};
         step_lo = {lo[XLEN-2:0], div_ok};
      end else begin
         step_hi = mul_sum[XLEN:1];
         step_lo = {mul_sum[0], lo[XLEN-1:1]};
      end
   end

   assign prod = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};

   always_comb begin
      case (m_f3)
         3'b000:                 m_res = prod[XLEN-1:0];
         3'b001, 3'b010, 3'b011: m_res = prod[2*XLEN-1:XLEN];
         3'b100, 3'b101:         m_res = neg_q ? -step_lo : step_lo;
         default:                m_res = neg_r ? -step_hi : step_hi;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         result    <= '0;
         illegal_q <= 1'b0;
         m_f3      <= '0;
         count     <= '0;
         opa       <= '0;
         hi        <= '0;
         lo        <= '0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (is_m) begin
                     m_f3  <= funct3;
                     count <= '0;
                     hi    <= '0;
                     if (funct3[2]) begin
                        opa   <= abs_b;
                        lo    <= abs_a;
                        // A zero divisor yields an all-ones quotient, never negated.
                        neg_q <= (a_neg ^ b_neg) & (input2_value != '0);
                        neg_r <= a_neg;
                     end else begin
                        opa   <= abs_a;
                        lo    <= abs_b;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= 1'b0;
                     end
                     state <= BUSY;
                  end else begin
                     result    <= sc_res;
                     illegal_q <= sc_ill;
                     state     <= DONE;
                  end
               end
            end
            BUSY: begin
               hi    <= step_hi;
               lo    <= step_lo;
               count <= count + 1'b1;
               if (count == LAST) begin
                  result    <= m_res;
                  illegal_q <= 1'b0;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;

   localparam int XLEN = 32;

   logic        clk = 1'b0;
   logic        reset, in_valid, in_ready, out_valid, out_ready, illegal;
   logic [6:0]  op_code, funct7;
   logic [2:0]  funct3;
   logic [31:0] input1_value, input2_value, alu_output_value;

   int n_checks = 0;
   int n_fail   = 0;

   seq_alu #(.XLEN(XLEN), .MULDIV_EN(1)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .op_code(op_code), .funct3(funct3), .funct7(funct7),
      .input1_value(input1_value), .input2_value(input2_value),
      .out_valid(out_valid), .out_ready(out_ready),
      .alu_output_value(alu_output_value), .illegal(illegal)
   );

   always #5 clk = ~clk;

   // Reference model: plain arithmetic on the instruction semantics.
   function automatic logic [31:0] ref_base(input logic [2:0] f3, input logic alt,
                                            input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (f3)
         3'd0:    return alt ? a - b : a + b;
         3'd1:    return a << b[4:0];
         3'd2:    return (sa < sb) ? 32'd1 : 32'd0;
         3'd3:    return (a < b) ? 32'd1 : 32'd0;
         3'd4:    return a ^ b;
         3'd5:    return alt ? 32'(sa >>> b[4:0]) : a >> b[4:0];
         3'd6:    return a | b;
         default: return a & b;
      endcase
   endfunction

   function automatic void ref_model(input logic [6:0] op, input logic [2:0] f3,
                                     input logic [6:0] f7, input logic [31:0] a,
                                     input logic [31:0] b, output logic [31:0] r,
                                     output logic il, output int lat);
      longint sa, sb;
      logic [63:0] p;
      logic ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      r = '0; il = 1'b0; lat = 1;
      case (op)
         7'b0110011: begin
            if (f7 == 7'h01) begin
               lat = XLEN + 1;
               case (f3)
                  3'd0: r = a * b;
                  3'd1: begin p = sa * sb; r = p[63:32]; end
                  3'd2: begin p = sa * longint'({32'b0, b}); r = p[63:32]; end
                  3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
                  3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
                  3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
                  3'd6: r = (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
                  default: r = (b == 0) ? a : a % b;
               endcase
            end else if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
               r = ref_base(f3, f7 == 7'h20, a, b);
            end else begin
               il = 1'b1;
            end
         end
         7'b0010011: r = ref_base(f3, (f3 == 3'd5) && b[10], a, b);
         7'b1100011: begin
            case (f3)
               3'd0: r = (a == b)  ? 32'd1 : 32'd0;
               3'd1: r = (a != b)  ? 32'd1 : 32'd0;
               3'd4: r = (sa < sb) ? 32'd1 : 32'd0;
               3'd5: r = (sa >= sb) ? 32'd1 : 32'd0;
               3'd6: r = (a < b)   ? 32'd1 : 32'd0;
               3'd7: r = (a >= b)  ? 32'd1 : 32'd0;
               default: il = 1'b1;
            endcase
         end
         7'b0000011, 7'b0100011, 7'b1101111, 7'b0010111: r = a + b;
         7'b1100111: r = (a + b) & ~32'h1;
         7'b0110111: r = b;
         default:    il = 1'b1;
      endcase
   endfunction

   // Issue one request and wait (bounded) for out_valid; does not consume it.
   task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b, input bit poke,
                        output logic [31:0] res, output logic il, output int lat);
      @(negedge clk);
      op_code = op; funct3 = f3; funct7 = f7;
      input1_value = a; input2_value = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      op_code = 7'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
      input1_value = $urandom; input2_value = $urandom;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 100) begin
         if (poke) in_valid = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         lat++;
      end
      in_valid = 1'b0;
      res = alu_output_value;
      il  = illegal;
   endtask

   task automatic consume();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_checks++; if (alu_output_value !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", alu_output_value); end
      n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b want 0", illegal); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   typedef struct {
      string       name;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] a, b, exp;
      logic        il;
      int          lat;
   } vec_t;

   task automatic test_directed();
      vec_t v[$];
      logic [31:0] res;
      logic il;
      int lat;
      v.push_back('{"add_ovf",  7'h33, 3'd0, 7'h00, 32'h7FFF_FFFF, 32'h1,   32'h8000_0000, 1'b0, 1});
      v.push_back('{"srai",     7'h13, 3'd5, 7'h00, 32'h8000_0000, 32'h404, 32'hF800_0000, 1'b0, 1});
      v.push_back('{"srli",     7'h13, 3'd5, 7'h00, 32'h8000_0000, 32'h004, 32'h0800_0000, 1'b0, 1});
      v.push_back('{"sra",      7'h33, 3'd5, 7'h20, 32'h8000_0010, 32'h24,  32'hF800_0001, 1'b0, 1});
      v.push_back('{"mulhu",    7'h33, 3'd3, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33});
      v.push_back('{"mul_neg",  7'h33, 3'd0, 7'h01, 32'hFFFF_FFFD, 32'd5,   32'hFFFF_FFF1, 1'b0, 33});
      v.push_back('{"mulh",     7'h33, 3'd1, 7'h01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 33});
      v.push_back('{"div_ovf",  7'h33, 3'd4, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 33});
      v.push_back('{"rem_ovf",  7'h33, 3'd6, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 33});
      v.push_back('{"divu_z",   7'h33, 3'd5, 7'h01, 32'd7, 32'd0, 32'hFFFF_FFFF, 1'b0, 33});
      v.push_back('{"remu_z",   7'h33, 3'd7, 7'h01, 32'd7, 32'd0, 32'd7, 1'b0, 33});
      v.push_back('{"div_neg",  7'h33, 3'd4, 7'h01, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33});
      v.push_back('{"rem_neg",  7'h33, 3'd6, 7'h01, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33});
      v.push_back('{"beq",      7'h63, 3'd0, 7'h00, 32'd5, 32'd5, 32'd1, 1'b0, 1});
      v.push_back('{"bgeu",     7'h63, 3'd7, 7'h00, 32'd3, 32'd5, 32'd0, 1'b0, 1});
      v.push_back('{"jalr",     7'h67, 3'd0, 7'h00, 32'h1000, 32'h3, 32'h1002, 1'b0, 1});
      v.push_back('{"lui",      7'h37, 3'd0, 7'h00, 32'h5555, 32'h1234_5000, 32'h1234_5000, 1'b0, 1});
      v.push_back('{"ill_op",   7'h7F, 3'd0, 7'h00, 32'd1, 32'd2, 32'd0, 1'b1, 1});
      v.push_back('{"ill_f7",   7'h33, 3'd1, 7'h20, 32'd1, 32'd2, 32'd0, 1'b1, 1});
      v.push_back('{"ill_br",   7'h63, 3'd2, 7'h00, 32'd1, 32'd1, 32'd0, 1'b1, 1});
      foreach (v[i]) begin
         issue(v[i].op, v[i].f3, v[i].f7, v[i].a, v[i].b, v[i].lat > 1, res, il, lat);
         n_checks++; if (res !== v[i].exp) begin n_fail++; $display("FAIL %s result: got %h want %h", v[i].name, res, v[i].exp); end
         n_checks++; if (il !== v[i].il) begin n_fail++; $display("FAIL %s illegal: got %b want %b", v[i].name, il, v[i].il); end
         n_checks++; if (lat != v[i].lat) begin n_fail++; $display("FAIL %s latency: got %0d want %0d", v[i].name, lat, v[i].lat); end
         consume();
      end
   endtask

   task automatic test_stall();
      logic [31:0] res;
      logic il;
      int lat;
      issue(7'h33, 3'd0, 7'h00, 32'd3, 32'd4, 1'b0, res, il, lat);
      for (int c = 0; c < 5; c++) begin
         in_valid = 1'b1;
         n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid c%0d: got %b want 1", c, out_valid); end
         n_checks++; if (alu_output_value !== 32'd7) begin n_fail++; $display("FAIL stall_result c%0d: got %h want 7", c, alu_output_value); end
         n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready c%0d: got %b want 0", c, in_ready); end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      consume();
      n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL stall_release: got ready %b valid %b want 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_reset_busy();
      logic [31:0] res;
      logic il;
      int lat;
      bit seen;
      @(negedge clk);
      op_code = 7'h33; funct3 = 3'd4; funct7 = 7'h01;
      input1_value = 32'd100; input2_value = 32'd7; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
         n_fail++; $display("FAIL busy_state: got valid %b ready %b want 0 0", out_valid, in_ready);
      end
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_busy_ready: got %b want 1", in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_busy_valid: got %b want 0", out_valid); end
      n_checks++; if (alu_output_value !== 32'h0 || illegal !== 1'b0) begin
         n_fail++; $display("FAIL rst_busy_result: got %h/%b want 0/0", alu_output_value, illegal);
      end
      @(negedge clk); reset = 1'b0;
      seen = 1'b0;
      repeat (40) begin @(posedge clk); #1; if (out_valid === 1'b1) seen = 1'b1; end
      n_checks++; if (seen) begin n_fail++; $display("FAIL rst_busy_discard: got out_valid 1 want 0"); end
      issue(7'h63, 3'd0, 7'h00, 32'd5, 32'd5, 1'b0, res, il, lat);
      n_checks++; if (res !== 32'd1 || il !== 1'b0) begin n_fail++; $display("FAIL post_rst_beq: got %h/%b want 1/0", res, il); end
      // Reset while in DONE drops the held result.
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b0 || alu_output_value !== 32'h0) begin
         n_fail++; $display("FAIL rst_done: got valid %b result %h want 0 0", out_valid, alu_output_value);
      end
      // Reset concurrent with in_valid must not accept.
      @(negedge clk);
      op_code = 7'h33; funct3 = 3'd0; funct7 = 7'h00;
      input1_value = 32'd1; input2_value = 32'd1; in_valid = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; in_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL rst_with_valid: got valid %b ready %b want 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_random();
      logic [6:0] ops[12] = '{7'h33, 7'h33, 7'h33, 7'h13, 7'h13, 7'h63,
                              7'h03, 7'h23, 7'h6F, 7'h67, 7'h17, 7'h37};
      logic [6:0] f7s[3] = '{7'h00, 7'h20, 7'h01};
      logic [31:0] corner[5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
      logic [6:0]  op, f7;
      logic [2:0]  f3;
      logic [31:0] a, b, res, er;
      logic        il, eil;
      int          idx, lat, elat;
      for (int n = 0; n < 150; n++) begin
         idx = $urandom_range(0, 12);
         op  = (idx == 12) ? 7'($urandom) : ops[idx];
         f3  = 3'($urandom);
         idx = $urandom_range(0, 3);
         f7  = (idx == 3) ? 7'($urandom) : f7s[idx];
         a   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
         b   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
         ref_model(op, f3, f7, a, b, er, eil, elat);
         issue(op, f3, f7, a, b, 1'b1, res, il, lat);
         n_checks++; if (res !== er) begin n_fail++; $display("FAIL rand%0d result op=%h f3=%0d f7=%h a=%h b=%h: got %h want %h", n, op, f3, f7, a, b, res, er); end
         n_checks++; if (il !== eil) begin n_fail++; $display("FAIL rand%0d illegal: got %b want %b", n, il, eil); end
         n_checks++; if (lat != elat) begin n_fail++; $display("FAIL rand%0d latency: got %0d want %0d", n, lat, elat); end
         consume();
      end
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      op_code = '0; funct3 = '0; funct7 = '0;
      input1_value = '0; input2_value = '0;
      test_reset();
      test_directed();
      test_stall();
      test_reset_busy();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
